// File: rtl/memory_stage_if.sv
// memory_stage_if: req/ack data-memory bus between the memory stage (master) and data memory (slave).
interface memory_stage_if #(
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/memory_stage.sv
// memory_stage: WISC memory stage that runs loads/stores over a req/ack bus, stalls upstream while an
// access is outstanding, and holds the MEM/WB pipeline register.
module memory_stage #(
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              reg_write_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] rd1_in,
    input  logic [3:0]        dstReg_in,
    memory_stage_if.master    bus,
    output logic              stall,
    output logic [DATA_W-1:0] wb_data_out,
    output logic [3:0]        wb_dstReg_out,
    output logic              wb_reg_write_out,
    output logic              mem_err
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_count;
    logic              r_req;
    logic              r_we;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_wb_data;
    logic [3:0]        r_wb_dst;
    logic              r_wb_rw;
    logic              r_err;
    logic              w_op;
    logic              w_timeout;

    assign w_op      = mem_read_in | mem_write_in;
    assign w_timeout = (r_count == CW'(MAX_WAIT - 1)) && !bus.mem_ack;
    // Gated by rst_n so reset releases upstream immediately, even with a memory op still presented
    assign stall     = rst_n && ((r_state == IDLE) ? w_op : !bus.mem_ack && !w_timeout);

    assign bus.mem_req       = r_req;
    assign bus.mem_we        = r_we;
    assign bus.mem_addr      = r_addr;
    assign bus.mem_wdata     = r_wdata;
    assign wb_data_out       = r_wb_data;
    assign wb_dstReg_out     = r_wb_dst;
    assign wb_reg_write_out  = r_wb_rw;
    assign mem_err           = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wb_data <= '0;
            r_wb_dst  <= '0;
            r_wb_rw   <= 1'b0;
            r_err     <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_op) begin
                r_state <= ACCESS;
                r_req   <= 1'b1;
                r_addr  <= alu_result_in;
                r_wdata <= rd1_in;
                r_we    <= mem_write_in;
                r_count <= '0;
                r_wb_rw <= 1'b0;
                r_err   <= r_err | (mem_read_in & mem_write_in);
            end else begin
                r_wb_data <= alu_result_in;
                r_wb_dst  <= dstReg_in;
                r_wb_rw   <= reg_write_in;
            end
        end else if (bus.mem_ack) begin
            r_state   <= IDLE;
            r_req     <= 1'b0;
            r_wb_data <= r_we ? alu_result_in : bus.mem_rdata;
            r_wb_dst  <= dstReg_in;
            r_wb_rw   <= reg_write_in;
        end else if (w_timeout) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            r_wb_rw <= 1'b0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end
endmodule
